top10_stream_out: RTL and testbench

TOP10_STREAM_OUT -- requirements
Module: top10_stream_out

---
 rtl/top10_pkg.sv | 24 ++
 rtl/top10_stream_out_if.sv | 35 +++
 rtl/top10_stream_out.sv | 108 ++++++++++
 tb/tb_top10_stream_out.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/top10_pkg.sv
// top10_pkg: shared defaults, rank type and FSM encoding
// for the top-N result streamer.
package top10_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int TOP_N_DEF      = 10;
    localparam int ID_WIDTH_DEF   = 6;
    localparam int RANK_W         = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    typedef logic [RANK_W-1:0] rank_t;

    function automatic logic rank_is_last(
        input rank_t r,
        input int    top_n
    );
        return r == rank_t'(top_n - 1);
    endfunction

endpackage

// File: rtl/top10_stream_out_if.sv
// top10_stream_out_if: valid/ready output stream carrying
// one ranked entry (value, ID, rank, last flag) per beat.
interface top10_stream_out_if
    import top10_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ID_WIDTH   = ID_WIDTH_DEF
);

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ID_WIDTH-1:0]   out_id;
    rank_t                 out_rank;
    logic                  out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_id,
        output out_rank,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_id,
        input  out_rank,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/top10_stream_out.sv
// top10_stream_out: captures a sorted top-N set on load and
// streams it out one entry per accepted beat, rank 0 first.
module top10_stream_out
    import top10_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int TOP_N      = TOP_N_DEF,
    parameter int ID_WIDTH   = ID_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [DATA_WIDTH*TOP_N-1:0] array_in,
    input  logic [ID_WIDTH*TOP_N-1:0]   id_in,
    output logic                        busy,
    output logic                        done,
    top10_stream_out_if.master          out_if
);

    state_e                state_q;
    state_e                state_d;
    rank_t                 rank_q;
    rank_t                 rank_d;
    logic                  done_q;
    logic                  done_d;
    logic                  capture;
    logic                  xfer;
    logic                  at_last;

    logic [DATA_WIDTH-1:0] val_q [TOP_N];
    logic [ID_WIDTH-1:0]   id_q  [TOP_N];

    assign busy    = (state_q == ST_SEND);
    assign done    = done_q;
    assign xfer    = busy && out_if.out_ready;
    assign at_last = rank_is_last(rank_q, TOP_N);

    // load is only honoured from IDLE, so a strobe during the
    // final transfer is dropped rather than chaining a new set.
    always_comb begin
        state_d = state_q;
        rank_d  = rank_q;
        done_d  = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    capture = 1'b1;
                    rank_d  = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    if (at_last) begin
                        state_d = ST_IDLE;
                        rank_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        rank_d = rank_q + rank_t'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rank_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rank_q  <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < TOP_N; i++) begin
                val_q[i] <= '0;
                id_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            rank_q  <= rank_d;
            done_q  <= done_d;
            if (capture) begin
                for (int i = 0; i < TOP_N; i++) begin
                    val_q[i] <= array_in[i*DATA_WIDTH +: DATA_WIDTH];
                    id_q[i]  <= id_in[i*ID_WIDTH +: ID_WIDTH];
                end
            end
        end
    end

    always_comb begin
        out_if.out_valid = 1'b0;
        out_if.out_data  = '0;
        out_if.out_id    = '0;
        out_if.out_rank  = '0;
        out_if.out_last  = 1'b0;
        if (busy) begin
            out_if.out_valid = 1'b1;
            out_if.out_data  = val_q[rank_q];
            out_if.out_id    = id_q[rank_q];
            out_if.out_rank  = rank_q;
            out_if.out_last  = at_last;
        end
    end

endmodule

// File: tb/tb_top10_stream_out.sv
// tb_top10_stream_out: table of result sets streamed through the
// DUT, checked beat by beat against a queue of expected entries.
module tb_top10_stream_out;

    localparam int DW = 16;
    localparam int N  = 10;
    localparam int IW = 6;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic [3:0]    rank;
        logic          last;
    } beat_t;

    typedef struct {
        logic [DW*N-1:0] arr;
        logic [IW*N-1:0] ids;
        int              mode;
        int              inj;
        int              exp_cyc;
    } vec_t;

    logic            clk;
    logic            rst_n;
    logic            load;
    logic [DW*N-1:0] array_in;
    logic [IW*N-1:0] id_in;
    logic            busy;
    logic            done;

    top10_stream_out_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) sif ();

    top10_stream_out #(
        .DATA_WIDTH(DW),
        .TOP_N     (N),
        .ID_WIDTH  (IW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .array_in(array_in),
        .id_in   (id_in),
        .busy    (busy),
        .done    (done),
        .out_if  (sif)
    );

    int    checks   = 0;
    int    failures = 0;
    int    done_cnt = 0;
    int    rdy_mode = 0;
    bit    mon_en   = 0;
    bit    prev_last = 0;
    bit    hold_v   = 0;
    beat_t held;
    beat_t e;
    beat_t exp_q [$];

    logic [DW*N-1:0] sevens;
    logic [IW*N-1:0] sev_ids;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(
        input string       name,
        input logic [63:0] act,
        input logic [63:0] exp
    );
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        sif.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       sif.out_ready = 1'b1;
                1:       sif.out_ready = ~sif.out_ready;
                default: sif.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy==valid", busy, sif.out_valid);
            if (prev_last) begin
                check("done after last", done, 1);
                check("valid drops after last", sif.out_valid, 0);
            end else begin
                check("no stray done", done, 0);
            end
            if (done) done_cnt++;
            prev_last = 0;
            if (!sif.out_valid) begin
                check("idle outputs zero",
                      {sif.out_data, sif.out_id, sif.out_rank, sif.out_last}, 0);
                hold_v = 0;
            end else begin
                if (hold_v) begin
                    check("hold data", sif.out_data, held.data);
                    check("hold id", sif.out_id, held.id);
                    check("hold rank", sif.out_rank, held.rank);
                    check("hold last", sif.out_last, held.last);
                end
                if (sif.out_ready) begin
                    check("queue nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("beat data", sif.out_data, e.data);
                        check("beat id", sif.out_id, e.id);
                        check("beat rank", sif.out_rank, e.rank);
                        check("beat last", sif.out_last, e.last);
                        prev_last = e.last;
                    end
                    hold_v = 0;
                end else begin
                    hold_v    = 1;
                    held.data = sif.out_data;
                    held.id   = sif.out_id;
                    held.rank = sif.out_rank;
                    held.last = sif.out_last;
                end
            end
        end
    end

    task automatic push_set(
        input logic [DW*N-1:0] arr,
        input logic [IW*N-1:0] ids
    );
        beat_t b;
        for (int i = 0; i < N; i++) begin
            b.data = arr[i*DW +: DW];
            b.id   = ids[i*IW +: IW];
            b.rank = 4'(i);
            b.last = (i == N - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic run_set(input vec_t v);
        int cyc;
        bit got;
        rdy_mode = v.mode;
        @(posedge clk);
        #1;
        load     = 1'b1;
        array_in = v.arr;
        id_in    = v.ids;
        push_set(v.arr, v.ids);
        @(posedge clk);
        #1;
        load = 1'b0;
        cyc  = 0;
        got  = 0;
        while (!got && cyc < 400) begin
            @(negedge clk);
            if (cyc == 0) check("valid one cycle after load", sif.out_valid, 1);
            if (done) begin
                got = 1;
            end else begin
                if (cyc == v.inj) begin
                    load     = 1'b1;
                    array_in = sevens;
                    id_in    = sev_ids;
                end else begin
                    load = 1'b0;
                end
                cyc++;
            end
        end
        load = 1'b0;
        check("done seen", got, 1);
        if (v.exp_cyc >= 0) check("cycles to done", cyc, v.exp_cyc);
        check("queue drained", exp_q.size(), 0);
    endtask

    vec_t tbl [6];
    vec_t fresh;
    logic [DW*N-1:0] a_arr, b_arr, z_arr, r_arr;
    logic [IW*N-1:0] a_ids, z_ids, r_ids;

    initial begin
        for (int i = 0; i < N; i++) begin
            a_arr[i*DW +: DW]   = DW'(100 - 10 * i);
            a_ids[i*IW +: IW]   = IW'(5 + i);
            b_arr[i*DW +: DW]   = DW'(1000 - 3 * i);
            z_arr[i*DW +: DW]   = '0;
            z_ids[i*IW +: IW]   = IW'(i);
            r_arr[i*DW +: DW]   = DW'($urandom);
            r_ids[i*IW +: IW]   = IW'($urandom);
            sevens[i*DW +: DW]  = DW'(7);
            sev_ids[i*IW +: IW] = IW'(63);
        end
        tbl[0] = '{a_arr, a_ids, 0, -1, N};
        tbl[1] = '{a_arr, a_ids, 1, -1, -1};
        tbl[2] = '{a_arr, a_ids, 0, 3, N};
        tbl[3] = '{b_arr, a_ids, 0, N - 1, N};
        tbl[4] = '{z_arr, z_ids, 0, -1, N};
        tbl[5] = '{r_arr, r_ids, 2, -1, -1};

        rst_n    = 1'b0;
        load     = 1'b1;
        array_in = a_arr;
        id_in    = a_ids;
        repeat (3) @(posedge clk);
        mon_en = 1;
        @(negedge clk);
        check("reset valid", sif.out_valid, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset data/id/rank/last",
              {sif.out_data, sif.out_id, sif.out_rank, sif.out_last}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load  = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("no start from reset load", sif.out_valid, 0);
        end

        for (int k = 0; k < 6; k++) run_set(tbl[k]);

        rdy_mode = 0;
        @(posedge clk);
        #1;
        load     = 1'b1;
        array_in = b_arr;
        id_in    = z_ids;
        push_set(b_arr, z_ids);
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (5) @(negedge clk);
        rst_n    = 1'b0;
        load     = 1'b1;
        array_in = sevens;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load  = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort valid", sif.out_valid, 0);
        check("abort busy", busy, 0);
        check("abort rank", sif.out_rank, 0);
        repeat (3) begin
            @(negedge clk);
            check("stays idle after abort", sif.out_valid, 0);
        end

        fresh = '{a_arr, z_ids, 0, -1, N};
        run_set(fresh);
        repeat (3) @(negedge clk);
        check("done pulse count", done_cnt, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
